// File: rtl/dmem_stream_pkg.sv
// dmem_stream_pkg: shared FSM state type and constants for the
// data-memory result streamer and its address generator.
package dmem_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      ISSUE,
      WAIT,
      HI,
      LO,
      FIN
   } state_t;

   localparam logic [7:0] HDR_SYNC           = 8'hA5;
   localparam int         ROW_STRIDE_DEFAULT = 64;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/dmem_matrix_addr_gen.sv
// dmem_matrix_addr_gen: row/col walker over an n x n row-major matrix.
// Ports: clk, rst (async high); load latches base_in/dim_in and clears
// row/col; advance steps col (then row); addr = base + row*stride + col
// truncated to ADDR_W; dim_q is the latched dimension; last flags the
// final element [n-1][n-1].
module dmem_matrix_addr_gen
   import dmem_stream_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DIM_W      = 7,
   parameter int ROW_STRIDE = ROW_STRIDE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [DIM_W-1:0]  dim_in,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic [DIM_W-1:0]  dim_q,
   output logic              last
);

   logic [ADDR_W-1:0] base_q;
   logic [DIM_W-1:0]  row_q;
   logic [DIM_W-1:0]  col_q;
   logic [DIM_W-1:0]  dim_m1;
   logic [ADDR_W-1:0] row_off;

   assign dim_m1 = dim_q - DIM_W'(1);

   // Power-of-two strides reduce to a shift; anything else multiplies.
   generate
      if (is_pow2(ROW_STRIDE)) begin : g_shift
         assign row_off = ADDR_W'(row_q) << $clog2(ROW_STRIDE);
      end else begin : g_mul
         assign row_off = ADDR_W'(row_q) * ADDR_W'(ROW_STRIDE);
      end
   endgenerate

   // Sum wraps modulo 2^ADDR_W by construction.
   assign addr = base_q + row_off + ADDR_W'(col_q);
   assign last = (row_q == dim_m1) && (col_q == dim_m1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         dim_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else if (load) begin
         base_q <= base_in;
         dim_q  <= dim_in;
         row_q  <= '0;
         col_q  <= '0;
      end else if (advance) begin
         if (col_q == dim_m1) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
         end else begin
            col_q <= col_q + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/dmem_result_streamer.sv
// dmem_result_streamer: reads an n x n matrix of 12-bit words from the
// data memory and streams each as two bytes (high nibble first) over a
// valid/ready link. Optional macro DUMP_HEADER_EN prefixes A5,{0,dim}.
// Ports: clk, rst (async high), start/base_addr/dim (command),
// mem_addr/mem_write_en/mem_rdata (memory read port),
// tx_data/tx_valid/tx_ready (byte link), busy, done (1-cycle pulse).
module dmem_result_streamer
   import dmem_stream_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 12,
   parameter int ROW_STRIDE = ROW_STRIDE_DEFAULT,
   parameter int DIM_W      = 7,
   parameter int MEM_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  dim,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_t            state_q;
   state_t            state_d;
   logic              load;
   logic              advance;
   logic              last;
   logic [ADDR_W-1:0] addr;
   logic [DIM_W-1:0]  dim_q;
   logic [DATA_W-1:0] word_q;
   logic [LAT_W-1:0]  lat_cnt;
   logic              lat_last;
   logic              done_q;

   dmem_matrix_addr_gen #(
      .ADDR_W     (ADDR_W),
      .DIM_W      (DIM_W),
      .ROW_STRIDE (ROW_STRIDE)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .base_in (base_addr),
      .dim_in  (dim),
      .advance (advance),
      .addr    (addr),
      .dim_q   (dim_q),
      .last    (last)
   );

   // Counters only move on LO acceptance, so the address is stable
   // from ISSUE through WAIT, HI and LO.
   assign mem_addr     = addr;
   assign mem_write_en = 1'b0;
   assign busy         = (state_q != IDLE) && (state_q != FIN);
   assign done         = done_q;
   assign lat_last     = (lat_cnt == LAT_W'(MEM_LAT - 1));

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      advance  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load = 1'b1;
               if (dim == '0) begin
                  state_d = FIN;
               end else begin
`ifdef DUMP_HEADER_EN
                  state_d = HDR0;
`else
                  state_d = ISSUE;
`endif
               end
            end
         end
`ifdef DUMP_HEADER_EN
         HDR0: begin
            tx_valid = 1'b1;
            tx_data  = HDR_SYNC;
            if (tx_ready) state_d = HDR1;
         end
         HDR1: begin
            tx_valid = 1'b1;
            tx_data  = 8'(dim_q);
            if (tx_ready) state_d = ISSUE;
         end
`endif
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (lat_last) state_d = HI;
         end
         HI: begin
            tx_valid = 1'b1;
            tx_data  = 8'(word_q >> 8);
            if (tx_ready) state_d = LO;
         end
         LO: begin
            tx_valid = 1'b1;
            tx_data  = word_q[7:0];
            if (tx_ready) begin
               advance = 1'b1;
               state_d = last ? FIN : ISSUE;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_cnt <= '0;
         word_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FIN);
         if (state_q == WAIT) begin
            if (lat_last) begin
               word_q  <= mem_rdata;
               lat_cnt <= '0;
            end else begin
               lat_cnt <= lat_cnt + LAT_W'(1);
            end
         end else begin
            lat_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_result_streamer.sv
// tb_dmem_result_streamer: random and directed dumps checked against
// a queue-based model of the expected byte stream and element addresses.
module tb_dmem_result_streamer;

`ifdef DUMP_HEADER_EN
   localparam int HOFF = 2;
`else
   localparam int HOFF = 0;
`endif

   typedef struct {
      logic [7:0]  b;
      bit          has_a;
      logic [11:0] a;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] base_addr;
   logic [6:0]  dim;
   logic [11:0] mem_addr;
   logic        mem_write_en;
   logic [11:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   logic [11:0] mem [4096];
   exp_t        exp_q [$];
   logic [7:0]  got_b [$];
   logic [11:0] got_a [$];

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int ready_mode = 0;
   bit prev_stall = 0;
   bit prev_done = 0;
   logic [7:0] prev_data = '0;

   dmem_result_streamer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .dim          (dim),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_rdata    (mem_rdata),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Registered-output data memory, one cycle of read latency.
   always @(posedge clk) mem_rdata <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Link-side ready: 0 = always, 1 = random, 2 = low once only the
   // two data bytes of the current (single) element remain.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) tx_ready = 1'b1;
         else if (ready_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
         else tx_ready = (exp_q.size() > 2);
      end
   end

   // Single compare process: every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
         prev_done  = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, prev_data);
         end
         if (tx_valid) begin
            chk("busy_while_valid", busy, 1);
            chk("write_en_low", mem_write_en, 0);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %h expected none", tx_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("byte", tx_data, e.b);
               if (e.has_a) begin
                  chk("elem_addr", mem_addr, e.a);
                  got_a.push_back(mem_addr);
               end
            end
            got_b.push_back(tx_data);
            acc_cnt++;
         end
         if (done) begin
            done_cnt++;
            chk("done_stream_empty", exp_q.size(), 0);
            chk("done_not_busy", busy, 0);
            chk("done_single_cycle", prev_done, 0);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_done  = done;
      end
   end

   // Model: header (optional), then row-major elements, high byte first.
   task automatic push_dump(input logic [11:0] b, input int n);
      exp_t e;
`ifdef DUMP_HEADER_EN
      if (n != 0) begin
         e.b = 8'hA5; e.has_a = 0; e.a = '0; exp_q.push_back(e);
         e.b = 8'(n); exp_q.push_back(e);
      end
`endif
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < n; c++) begin
            logic [11:0] a;
            logic [11:0] w;
            a = 12'(int'(b) + r * 64 + c);
            w = mem[a];
            e.b = {4'h0, w[11:8]}; e.has_a = 1; e.a = a; exp_q.push_back(e);
            e.b = w[7:0]; e.has_a = 0; exp_q.push_back(e);
         end
      end
   endtask

   task automatic do_start(input logic [11:0] b, input logic [6:0] d);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = b;
      dim = d;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles", budget);
      end
   endtask

   task automatic run_dump(input logic [11:0] b, input int n, input bit spur);
      int d0;
      got_b.delete();
      got_a.delete();
      push_dump(b, n);
      d0 = done_cnt;
      do_start(b, 7'(n));
      if (spur && n != 0) do_start(~b, 7'(n + 1));
      wait_done(d0, 300 + 60 * n * n);
      repeat (3) @(negedge clk);
      #2;
      chk("done_count", done_cnt - d0, 1);
      chk("model_drained", exp_q.size(), 0);
      chk("stream_len", got_b.size(), (n == 0) ? 0 : 2 * n * n + HOFF);
   endtask

   initial begin
      logic [7:0]  lit1 [8];
      logic [11:0] adr1 [4];
      logic [11:0] adr5 [4];
      int d0;
      int k;

      lit1 = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
      adr1 = '{12'd4, 12'd5, 12'd68, 12'd69};
      adr5 = '{12'hFFF, 12'h000, 12'h03F, 12'h040};

      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      dim = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);

      #3;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_write_en", mem_write_en, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: 2x2 literal dump
      mem[4] = 12'd1; mem[5] = 12'd2; mem[68] = 12'd3; mem[69] = 12'd4;
      ready_mode = 0;
      run_dump(12'd4, 2, 0);
      for (int i = 0; i < 8; i++) chk("t1_byte", got_b[HOFF + i], lit1[i]);
      for (int i = 0; i < 4; i++) chk("t1_addr", got_a[i], adr1[i]);
`ifdef DUMP_HEADER_EN
      chk("t1_hdr0", got_b[0], 8'hA5);
      chk("t1_hdr1", got_b[1], 8'h02);
`endif

      // 2: backpressure on the high byte
      mem[4] = 12'hABC;
      ready_mode = 2;
      got_b.delete();
      got_a.delete();
      push_dump(12'd4, 1);
      d0 = done_cnt;
      do_start(12'd4, 7'd1);
      k = 0;
      while (!(tx_valid && !tx_ready) && k < 50) begin
         @(negedge clk);
         #2;
         k++;
      end
      chk("t2_stall_seen", tx_valid && !tx_ready, 1);
      chk("t2_hold_data", tx_data, 8'h0A);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         chk("t2_hold_valid", tx_valid, 1);
         chk("t2_hold_data", tx_data, 8'h0A);
      end
      ready_mode = 0;
      wait_done(d0, 50);
      chk("t2_hi", got_b[HOFF], 8'h0A);
      chk("t2_lo", got_b[HOFF + 1], 8'hBC);
      chk("t2_done_count", done_cnt - d0, 1);

      // 3: dim == 0
      d0 = done_cnt;
      do_start(12'h123, 7'd0);
      @(negedge clk);
      #2;
      chk("t3_done_early", done, 0);
      chk("t3_busy", busy, 0);
      chk("t3_valid", tx_valid, 0);
      @(negedge clk);
      #2;
      chk("t3_done", done, 1);
      chk("t3_busy2", busy, 0);
      repeat (3) @(negedge clk);
      #2;
      chk("t3_done_count", done_cnt - d0, 1);

      // 4: reset mid-stream, then full restart
      got_b.delete();
      push_dump(12'h200, 4);
      d0 = done_cnt;
      k = acc_cnt;
      do_start(12'h200, 7'd4);
      while (acc_cnt < k + 3 && done_cnt == d0) begin
         @(negedge clk);
         #2;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t4_valid_drop", tx_valid, 0);
      chk("t4_busy_drop", busy, 0);
      chk("t4_data_clr", tx_data, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      chk("t4_no_done", done_cnt - d0, 0);
      run_dump(12'h200, 4, 0);

      // 5: address wrap
      run_dump(12'hFFF, 2, 0);
      for (int i = 0; i < 4; i++) chk("t5_addr", got_a[i], adr5[i]);

      // 6: start while busy is ignored
      run_dump(12'h040, 2, 1);
`ifdef DUMP_HEADER_EN
      chk("t6_hdr0", got_b[0], 8'hA5);
      chk("t6_hdr1", got_b[1], 8'h02);
`endif
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      #2;
      chk("t6_no_second_dump", done_cnt - d0, 0);

      // Random dumps under random backpressure
      ready_mode = 1;
      for (int it = 0; it < 25; it++) begin
         for (int j = 0; j < 40; j++) mem[$urandom_range(0, 4095)] = 12'($urandom);
         run_dump(12'($urandom), $urandom_range(0, 6), $urandom_range(0, 2) == 0);
      end

      ready_mode = 0;
      repeat (5) @(negedge clk);
      #2;
      chk("end_idle_busy", busy, 0);
      chk("end_idle_valid", tx_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
